ucaspian_dendrite: RTL
======================

Name: ucaspian_dendrite

Overview:
Dendritic accumulator: the consumer end of the synapse-to-dendrite fire stream. It accepts (target neuron, signed 8-bit charge) fires over a valid/ready handshake and accumulates them per neuron into a 16-bit saturating accumulator RAM. On a drain request it sweeps all touched neurons, emits each non-zero total to the neuron unit, and returns the entries to zero. It sits between ucaspian_synapse and the neuron unit.

Parameters:
NUM_NEURONS, 256, accumulator entries; address width is 8.
ACC_WIDTH, 16, signed accumulator width.

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
clear_act  input  1  discard all accumulated charge
clear_done  output  1  clear acknowledge
drain_start  input  1  single-cycle request to sweep accumulators to the neuron unit
drain_done  output  1  single-cycle pulse when the sweep completes
step_done  output  1  registered idle indication for time sync
dend_addr  input  8  target neuron of incoming fire
dend_charge  input  8  signed weight of incoming fire
dend_vld  input  1  fire valid
dend_rdy  output  1  fire ready
neuron_addr  output  8  neuron being delivered
neuron_charge  output  16  signed accumulated charge
neuron_vld  output  1  delivery valid
neuron_rdy  input  1  delivery ready

Behaviour:
- Storage: NUM_NEURONS x ACC_WIDTH RAM with 1-cycle registered read, plus a NUM_NEURONS-bit dirty bitmap in flops. A clear dirty bit means the entry reads as 0, whatever the RAM holds. The RAM itself is never reset.
- Reset (asynchronous): state ACCUM, dirty bitmap all 0, pipeline empty, pending-drain flag 0.
- Output values during reset: neuron_vld=0, neuron_addr=0, neuron_charge=0, drain_done=0, clear_done=0, step_done=0.
- States:
  - ACCUM
    - Accepts fires. dend_rdy = (state==ACCUM) && !drain_pending && !clear_act.
    - Accept happens on dend_vld && dend_rdy.
    - Cycle 0: RAM read of dend_addr. Cycle 1: add the sign-extended charge to the old value (old value = 0 if not dirty), saturate, write back, set the dirty bit.
    - Sustained throughput is 1 fire/cycle.
    - Forwarding: when a stage-1 write targets the same address as the stage-0 read in that cycle, stage 1 of the next fire uses the just-written value, not the RAM output.
  - DRAIN
    - Entered when drain_pending is set and the accumulate pipeline is empty.
    - A scan index walks 0..NUM_NEURONS-1 at 1 address/cycle.
    - Non-dirty addresses are skipped.
    - Dirty address: read the RAM, then clear the dirty bit.
      - Non-zero value: present neuron_addr/neuron_charge with neuron_vld=1 and hold until neuron_rdy, then advance.
      - Zero value: no output.
    - After index NUM_NEURONS-1 is processed: drain_done pulses for 1 cycle, drain_pending clears, state returns to ACCUM.
  - CLEAR
    - Active while clear_act=1: dirty bitmap zeroed in one cycle; neuron_vld, in-flight pipeline and drain_pending dropped.
    - clear_done is registered: it equals clear_act delayed one cycle.
    - Returns to ACCUM when clear_act falls.
- drain_start is latched into drain_pending. It has effect in any state other than CLEAR. Repeat requests while pending are ignored.
- Priority when events coincide: clear_act > drain_start > fire accept. A fire accepted in the same cycle drain_start rises still completes before DRAIN starts.
- Arithmetic: the sign-extended 8-bit charge is added to the 16-bit accumulator. The result saturates at +32767 / -32768 and never wraps.
- step_done is registered: 1 when state==ACCUM, !dend_vld, pipeline empty, !drain_pending and !neuron_vld.
- Reset asserted mid-sweep or mid-write abandons the operation. The accumulators become logically empty because all dirty bits are cleared.

Test Plan:
1. Fires (5,+10), (5,-3), (9,+127) on consecutive cycles, then drain_start, with neuron_rdy=1 → deliveries in order (5,7) then (9,127), drain_done pulse, step_done=1 afterwards.
2. 300 back-to-back fires (3,+127) → a single delivery (3,32767); saturation holds, no wrap. Repeat with (3,-128) x 300 → delivery (3,-32768).
3. Fires (4,+20), (4,-20), then drain → no delivery for 4, drain_done still pulses. A second drain delivers nothing.
4. Drain over dirty neurons 0, 128, 255 with neuron_rdy held low 5 cycles per item → neuron_vld/neuron_addr/neuron_charge stable while stalled, order 0, 128, 255, dend_rdy=0 throughout.
5. Accumulate into neurons 1 and 2, pulse clear_act 1 cycle → clear_done=1 the next cycle. A subsequent fire (1,+1) followed by drain delivers exactly (1,1).
6. Assert reset mid-drain while neuron_vld=1 → outputs immediately at reset values; after release a drain delivers nothing.

Source files
------------

// File: rtl/ucaspian_dendrite.sv
// Dendritic accumulator: sums incoming (neuron, charge) fires into a saturating per-neuron RAM
// and sweeps the touched entries out to the neuron unit on request.
module ucaspian_dendrite #(
    parameter int NUM_NEURONS = 256,
    parameter int ACC_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear_act,
    output logic                 clear_done,
    input  logic                 drain_start,
    output logic                 drain_done,
    output logic                 step_done,
    input  logic [7:0]           dend_addr,
    input  logic [7:0]           dend_charge,
    input  logic                 dend_vld,
    output logic                 dend_rdy,
    output logic [7:0]           neuron_addr,
    output logic [ACC_WIDTH-1:0] neuron_charge,
    output logic                 neuron_vld,
    input  logic                 neuron_rdy
);

    localparam logic [1:0] StAccum = 2'd0;
    localparam logic [1:0] StDrain = 2'd1;
    localparam logic [1:0] StClear = 2'd2;
    localparam logic [7:0] LastAddr = 8'(NUM_NEURONS - 1);

    logic [1:0]             state_q;
    logic [NUM_NEURONS-1:0] dirty_q;
    logic                   drain_pending_q;

    logic                   p1_vld_q;
    logic [7:0]             p1_addr_q;
    logic [7:0]             p1_charge_q;
    logic                   fwd_q;
    logic [ACC_WIDTH-1:0]   fwd_data_q;

    logic [ACC_WIDTH-1:0]   mem [NUM_NEURONS];
    logic [ACC_WIDTH-1:0]   ram_rd_q;

    logic [7:0]             scan_q;
    logic                   scan_done_q;
    logic                   d1_vld_q;
    logic [7:0]             d1_addr_q;

    logic                   neuron_vld_q;
    logic [7:0]             neuron_addr_q;
    logic [ACC_WIDTH-1:0]   neuron_charge_q;
    logic                   drain_done_q;
    logic                   clear_done_q;
    logic                   step_done_q;

    logic                   accept;
    logic                   drain_run;
    logic                   out_busy;
    logic                   d1_move;
    logic                   scan_adv;
    logic                   scan_dirty;
    logic                   drain_fin;
    logic                   ram_re;
    logic [7:0]             ram_raddr;
    logic [ACC_WIDTH-1:0]   old_val;
    logic [ACC_WIDTH:0]     sum_ext;
    logic [ACC_WIDTH-1:0]   sat_sum;

    assign dend_rdy   = (state_q == StAccum) && !drain_pending_q && !clear_act;
    assign accept     = dend_vld && dend_rdy;
    assign drain_run  = (state_q == StDrain) && !clear_act;
    assign out_busy   = neuron_vld_q && !neuron_rdy;
    assign d1_move    = drain_run && d1_vld_q && !out_busy;
    assign scan_dirty = dirty_q[scan_q];
    assign scan_adv   = drain_run && !scan_done_q && !(d1_vld_q && out_busy);
    assign drain_fin  = drain_run && scan_done_q && !d1_vld_q && !neuron_vld_q;
    assign ram_re     = accept || (scan_adv && scan_dirty);
    assign ram_raddr  = accept ? dend_addr : scan_q;

    // Clean entries read as zero; a write-then-read of the same address takes the forwarded sum.
    always_comb begin
        old_val = '0;
        if (dirty_q[p1_addr_q]) begin
            old_val = fwd_q ? fwd_data_q : ram_rd_q;
        end
        sum_ext = {old_val[ACC_WIDTH-1], old_val}
                + {{(ACC_WIDTH-7){p1_charge_q[7]}}, p1_charge_q};
        if (sum_ext[ACC_WIDTH] != sum_ext[ACC_WIDTH-1]) begin
            sat_sum = sum_ext[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                         : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end else begin
            sat_sum = sum_ext[ACC_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (p1_vld_q && !clear_act) begin
            mem[p1_addr_q] <= sat_sum;
        end
        if (ram_re) begin
            ram_rd_q <= mem[ram_raddr];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= StAccum;
            dirty_q         <= '0;
            drain_pending_q <= 1'b0;
            p1_vld_q        <= 1'b0;
            p1_addr_q       <= '0;
            p1_charge_q     <= '0;
            fwd_q           <= 1'b0;
            fwd_data_q      <= '0;
            scan_q          <= '0;
            scan_done_q     <= 1'b0;
            d1_vld_q        <= 1'b0;
            d1_addr_q       <= '0;
            neuron_vld_q    <= 1'b0;
            neuron_addr_q   <= '0;
            neuron_charge_q <= '0;
            drain_done_q    <= 1'b0;
            clear_done_q    <= 1'b0;
            step_done_q     <= 1'b0;
        end else begin
            clear_done_q <= clear_act;
            drain_done_q <= drain_fin;
            step_done_q  <= (state_q == StAccum) && !dend_vld && !p1_vld_q
                            && !drain_pending_q && !neuron_vld_q;
            if (clear_act) begin
                state_q         <= StClear;
                dirty_q         <= '0;
                drain_pending_q <= 1'b0;
                p1_vld_q        <= 1'b0;
                fwd_q           <= 1'b0;
                d1_vld_q        <= 1'b0;
                neuron_vld_q    <= 1'b0;
                scan_q          <= '0;
                scan_done_q     <= 1'b0;
            end else begin
                if (drain_start && (state_q != StClear)) begin
                    drain_pending_q <= 1'b1;
                end
                p1_vld_q <= accept;
                if (accept) begin
                    p1_addr_q   <= dend_addr;
                    p1_charge_q <= dend_charge;
                end
                fwd_q      <= accept && p1_vld_q && (p1_addr_q == dend_addr);
                fwd_data_q <= sat_sum;
                if (p1_vld_q) begin
                    dirty_q[p1_addr_q] <= 1'b1;
                end
                case (state_q)
                    StClear: state_q <= StAccum;
                    StAccum: begin
                        if (drain_pending_q && !p1_vld_q) begin
                            state_q     <= StDrain;
                            scan_q      <= '0;
                            scan_done_q <= 1'b0;
                        end
                    end
                    StDrain: begin
                        if (scan_adv) begin
                            dirty_q[scan_q] <= 1'b0;
                            d1_vld_q        <= scan_dirty;
                            d1_addr_q       <= scan_q;
                            scan_q          <= scan_q + 8'd1;
                            if (scan_q == LastAddr) begin
                                scan_done_q <= 1'b1;
                            end
                        end else if (d1_move) begin
                            d1_vld_q <= 1'b0;
                        end
                        if (neuron_vld_q && neuron_rdy) begin
                            neuron_vld_q <= 1'b0;
                        end
                        // Entries that summed back to zero are retired silently.
                        if (d1_move && (ram_rd_q != '0)) begin
                            neuron_vld_q    <= 1'b1;
                            neuron_addr_q   <= d1_addr_q;
                            neuron_charge_q <= ram_rd_q;
                        end
                        if (drain_fin) begin
                            drain_pending_q <= 1'b0;
                            state_q         <= StAccum;
                        end
                    end
                    default: state_q <= StAccum;
                endcase
            end
        end
    end

    assign neuron_vld    = neuron_vld_q;
    assign neuron_addr   = neuron_addr_q;
    assign neuron_charge = neuron_charge_q;
    assign drain_done    = drain_done_q;
    assign clear_done    = clear_done_q;
    assign step_done     = step_done_q;

endmodule
